// File: rtl/serial_work_rx_if.sv
// Host-link receive bundle: serial line in, assembled work frame and status out.
// The line source uses master; the receiver uses slave.
interface serial_work_rx_if #(
    parameter int unsigned NBYTES = 84
);
    logic                  RxD;
    logic [8*NBYTES-1:0]   rx_data;
    logic                  rx_done;
    logic                  frame_err;
    logic [6:0]            byte_count;
    logic                  busy;

    modport master (
        output RxD,
        input  rx_data, rx_done, frame_err, byte_count, busy
    );

    modport slave (
        input  RxD,
        output rx_data, rx_done, frame_err, byte_count, busy
    );
endinterface

// File: rtl/serial_work_rx.sv
// 8N1 UART receiver that shifts good bytes into a work register and publishes
// the whole frame with a one-cycle rx_done strobe on the NBYTES-th byte.
module serial_work_rx #(
    parameter int unsigned comm_clk_frequency = 100_000_000,
    parameter int unsigned baud_rate          = 115_200,
    parameter int unsigned NBYTES             = 84,
    parameter int unsigned TIMEOUT_CYCLES     = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    serial_work_rx_if.slave bus
);
    localparam int unsigned D  = comm_clk_frequency / baud_rate;
    localparam int unsigned CW = $clog2(D + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned W  = 8 * NBYTES;

    generate
        if (D < 4) begin : g_divisor_check
            $error("serial_work_rx: clock/baud divisor must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rxs_q, rxs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      byte_q, byte_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    rx_data_q, rx_data_d;
    logic [6:0]      byte_count_q, byte_count_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;
    logic            expire;

    assign expire = (cnt_q == CW'(1));

    always_comb begin
        state_d      = state_q;
        sync1_d      = bus.RxD;
        rxs_d        = sync1_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        byte_d       = byte_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        byte_count_d = byte_count_q;
        idle_d       = idle_q;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A start edge takes priority over a timeout landing on the same cycle.
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = CW'(D / 2);
                    idle_d  = '0;
                end else if (byte_count_q != '0) begin
                    if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        byte_count_d = '0;
                        idle_d       = '0;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            START: begin
                cnt_d = cnt_q - CW'(1);
                if (expire) begin
                    if (!rxs_q) begin
                        state_d = DATA;
                        cnt_d   = CW'(D);
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q - CW'(1);
                if (expire) begin
                    byte_d = {rxs_q, byte_q[7:1]};
                    cnt_d  = CW'(D);
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q - CW'(1);
                if (expire) begin
                    state_d = IDLE;
                    if (rxs_q) begin
                        shift_d = {shift_q[W-9:0], byte_q};
                        if (byte_count_q == 7'(NBYTES - 1)) begin
                            rx_data_d    = shift_d;
                            rx_done_d    = 1'b1;
                            byte_count_d = '0;
                        end else begin
                            byte_count_d = byte_count_q + 7'd1;
                        end
                    end else begin
                        frame_err_d  = 1'b1;
                        byte_count_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchroniser resets to the idle-high line level so reset release is not seen as a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            byte_count_q <= '0;
            idle_q       <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rxs_q        <= rxs_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            byte_count_q <= byte_count_d;
            idle_q       <= idle_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_done    = rx_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.byte_count = byte_count_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_work_rx.sv
// Randomised bench for serial_work_rx: a line driver feeds 8N1 characters while a
// byte-queue model predicts frames, counts, strobes and their latency.
module tb_serial_work_rx;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 115_200;
    localparam int unsigned NB     = 84;
    localparam int unsigned TO     = 500;
    localparam int unsigned D      = CLK_HZ / BAUD;
    localparam int unsigned W      = 8 * NB;
    localparam int          LAT    = 3 + D / 2 + 9 * D;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_work_rx_if #(.NBYTES(NB)) bus ();

    serial_work_rx #(
        .comm_clk_frequency(CLK_HZ),
        .baud_rate(BAUD),
        .NBYTES(NB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    q_acc[$];
    logic [W-1:0]  exp_frames[$];
    logic [W-1:0]  last_frame = '0;
    int            ferr_exp = 0, ferr_seen = 0, done_seen = 0, busy_total = 0;
    int            cyc = 0, start_cyc = 0, idle_run = 0;
    logic [7:0]    std_word[NB];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_frame();
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(NB); i++) r[W-1-8*i -: 8] = q_acc[i];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy) busy_total++;
            if (bus.rx_done) begin
                done_seen++;
                chk("done_latency", cyc - start_cyc, LAT);
                chk("bc_at_done", bus.byte_count, 0);
                chk("done_expected", exp_frames.size() != 0, 1);
                if (exp_frames.size() != 0) chk("rx_data_done", bus.rx_data, exp_frames.pop_front());
            end
            if (bus.frame_err) begin
                ferr_seen++;
                chk("ferr_latency", cyc - start_cyc, LAT);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with no extra gap, so calls chain back-to-back.
    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic [9:0]   frame;
        logic [W-1:0] f = '0;
        bit           completed = 1'b0;
        if (bad) begin
            ferr_exp++;
            q_acc.delete();
        end else begin
            q_acc.push_back(b);
            if (q_acc.size() == NB) begin
                f = model_frame();
                exp_frames.push_back(f);
                q_acc.delete();
                completed = 1'b1;
            end
        end
        idle_run  = 0;
        frame     = {~bad, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            bus.RxD = frame[i];
            repeat (D) @(posedge clk);
            #1;
        end
        if (completed) last_frame = f;
        chk("byte_count", bus.byte_count, q_acc.size());
        chk("rx_data_hold", bus.rx_data, last_frame);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        idle_run += n;
        if (idle_run >= int'(TO) + 10) q_acc.delete();
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(255)), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, b0;
        bus.RxD = 1'b1;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_done", bus.rx_done, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_byte_count", bus.byte_count, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        idle(2 * D);

        for (int i = 0; i < int'(NB); i++) std_word[i] = 8'($urandom_range(255));
        std_word[0] = 8'h00; std_word[1] = 8'h00; std_word[2] = 8'h07; std_word[3] = 8'hff;
        std_word[4] = 8'h00; std_word[5] = 8'h00; std_word[6] = 8'h31; std_word[7] = 8'h8e;
        std_word[80] = 8'h01; std_word[81] = 8'h00; std_word[82] = 8'h00; std_word[83] = 8'h00;

        // Standard work word.
        d0 = done_seen; f0 = ferr_seen;
        for (int i = 0; i < int'(NB); i++) send_byte(std_word[i], 1'b0);
        chk("std_done_count", done_seen - d0, 1);
        chk("std_ferr_count", ferr_seen - f0, 0);
        chk("std_top_byte", bus.rx_data[W-1 -: 8], 8'h00);

        // Bad stop on byte 10, then a clean frame.
        d0 = done_seen;
        for (int i = 0; i <= 10; i++) send_byte(std_word[i], i == 10);
        chk("err_byte_count", bus.byte_count, 0);
        send_random(NB);
        chk("err_done_count", done_seen - d0, 1);

        // Partial frame, idle glitch, then timeout.
        send_random(40);
        b0 = busy_total; f0 = ferr_seen;
        bus.RxD = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.RxD  = 1'b1;
        idle_run = 0;
        idle(2 * D);
        chk("glitch_busy_cycles", busy_total - b0, D / 2);
        chk("glitch_byte_count", bus.byte_count, 40);
        chk("glitch_busy_low", bus.busy, 0);
        idle(TO - 80);
        chk("pre_timeout_count", bus.byte_count, 40);
        d0 = done_seen;
        idle(100);
        chk("timeout_count", bus.byte_count, 0);
        chk("timeout_no_done", done_seen - d0, 0);
        chk("timeout_ferr", ferr_seen - f0, 0);
        chk("timeout_rx_data_hold", bus.rx_data, last_frame);
        send_random(NB);
        chk("post_timeout_done", done_seen - d0, 1);

        // Frame error on the last byte of a frame.
        d0 = done_seen;
        send_random(NB - 1);
        send_byte(8'($urandom_range(255)), 1'b1);
        chk("lastbyte_err_no_done", done_seen - d0, 0);

        // Reset in the middle of byte 50.
        send_random(49);
        bus.RxD = 1'b0;
        repeat (D) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            bus.RxD = 1'($urandom_range(1));
            repeat (D) @(posedge clk);
        end
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_rx_data", bus.rx_data, 0);
        chk("midrst_rx_done", bus.rx_done, 0);
        chk("midrst_frame_err", bus.frame_err, 0);
        chk("midrst_byte_count", bus.byte_count, 0);
        chk("midrst_busy", bus.busy, 0);
        q_acc.delete();
        exp_frames.delete();
        last_frame = '0;
        bus.RxD    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(10 * D);
        d0 = done_seen;
        send_random(NB);
        chk("postrst_done", done_seen - d0, 1);

        // Two frames with no inter-character gap.
        d0 = done_seen;
        send_random(2 * NB);
        chk("b2b_done_count", done_seen - d0, 2);

        // Random gaps and occasional bad stop bits.
        for (int i = 0; i < 80; i++) begin
            send_byte(8'($urandom_range(255)), $urandom_range(15) == 0);
            if ($urandom_range(3) == 0) idle($urandom_range(20));
        end

        idle(2 * D);
        chk("ferr_total", ferr_seen, ferr_exp);
        chk("frames_pending", exp_frames.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
